// File: rtl/wb_pkg.sv
// Shared types for the beta pipeline write-back stage.
//  wb_state_e : slot FSM states
//  wb_sel_e   : register-file write source
//  ZERO_REG   : hard-wired zero register (R31) at the default address width
package wb_pkg;

   typedef enum logic [1:0] {
      EMPTY    = 2'd0,
      ACTIVE   = 2'd1,
      LD_WAIT  = 2'd2,
      LD_DRAIN = 2'd3
   } wb_state_e;

   typedef enum logic [1:0] {
      WB_SEL_ALU  = 2'd0,
      WB_SEL_MEM  = 2'd1,
      WB_SEL_PC   = 2'd2,
      WB_SEL_NONE = 2'd3
   } wb_sel_e;

   localparam int RA_W_DEF = 5;
   // The zero register is always the all-ones address, whatever RA_W is.
   localparam logic [RA_W_DEF-1:0] ZERO_REG = '1;

endpackage

// File: rtl/wb_sel_decode.sv
// Write-source decoder for the write-back stage (combinational).
//  op_ld, op_st, op_jump : opcode class flags from MEM
//  sel                   : write source, priority jump > ld > st > alu
//  err                   : more than one class flag set
module wb_sel_decode
   import wb_pkg::*;
(
   input  logic    op_ld,
   input  logic    op_st,
   input  logic    op_jump,
   output wb_sel_e sel,
   output logic    err
);

   always_comb begin
      sel = WB_SEL_ALU;
      if (op_jump)    sel = WB_SEL_PC;
      else if (op_ld) sel = WB_SEL_MEM;
      else if (op_st) sel = WB_SEL_NONE;
   end

   assign err = (op_ld & op_st) | (op_ld & op_jump) | (op_st & op_jump);

endmodule

// File: rtl/wb_stage_hs.sv
// Handshaked write-back stage: one-instruction slot between MEM and the
// register file, with variable-latency load wait, kill, load timeout,
// forwarding port and retire counter.
//  clk, rst_n              : clock, async active-low reset
//  in_valid/in_ready       : MEM -> slot handshake (transfer when both high)
//  in_pc/ir/y/op_*         : captured instruction fields
//  in_kill                 : discard the instruction in the slot
//  mem_rd_valid/mem_rd     : load return data (used combinationally)
//  rf_we/rf_w_addr/w_data  : register-file write port
//  fwd_*                   : bypass info about the slot contents
//  ir_out                  : instruction word held in the slot
//  retire_count            : committed instructions (wraps)
//  err_ld_timeout/err_sel  : sticky error flags
//  dbg_state               : current FSM state
module wb_stage_hs
   import wb_pkg::*;
#(
   parameter int DATA_W     = 32,
   parameter int RA_W       = RA_W_DEF,
   parameter int LD_TIMEOUT = 64,
   parameter int CNT_W      = 32
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W-1:0] in_pc,
   input  logic [DATA_W-1:0] in_ir,
   input  logic [DATA_W-1:0] in_y,
   input  logic              in_op_ld,
   input  logic              in_op_st,
   input  logic              in_op_jump,
   input  logic              in_kill,
   input  logic              mem_rd_valid,
   input  logic [DATA_W-1:0] mem_rd,
   output logic              rf_we,
   output logic [RA_W-1:0]   rf_w_addr,
   output logic [DATA_W-1:0] rf_w_data,
   output logic              fwd_valid,
   output logic              fwd_pending,
   output logic [RA_W-1:0]   fwd_addr,
   output logic [DATA_W-1:0] fwd_data,
   output logic [DATA_W-1:0] ir_out,
   output logic [CNT_W-1:0]  retire_count,
   output logic              err_ld_timeout,
   output logic              err_sel,
   output wb_state_e         dbg_state
);

   // Handshake: a transfer happens on a rising edge where in_valid and
   // in_ready are both high; in_valid must not depend on in_ready.

   localparam int TO_W = (LD_TIMEOUT > 0) ? $clog2(LD_TIMEOUT + 1) : 1;
   localparam logic [TO_W-1:0] TO_LIMIT = TO_W'(LD_TIMEOUT);

   wb_state_e         state_q, state_d;
   logic [DATA_W-1:0] pc_q, pc_d, ir_q, ir_d, y_q, y_d;
   logic              ld_q, ld_d, st_q, st_d;
   wb_sel_e           sel_q, sel_d;
   logic [TO_W-1:0]   to_cnt_q, to_cnt_d;
   logic [CNT_W-1:0]  retire_q, retire_d;
   logic              err_to_q, err_to_d, err_sel_q, err_sel_d;

   wb_sel_e           dec_sel;
   logic              dec_err;
   logic              commit, ready_c, slot_busy, writes, pending;
   logic [RA_W-1:0]   rc;
   logic [DATA_W-1:0] wdata;

   wb_sel_decode u_dec (
      .op_ld   (in_op_ld),
      .op_st   (in_op_st),
      .op_jump (in_op_jump),
      .sel     (dec_sel),
      .err     (dec_err)
   );

   assign rc        = ir_q[21 +: RA_W];
   assign slot_busy = (state_q == ACTIVE) || (state_q == LD_WAIT);
   assign writes    = !st_q && (sel_q != WB_SEL_NONE) && (rc != {RA_W{1'b1}});
   assign pending   = slot_busy && ld_q && !mem_rd_valid;

   always_comb begin
      wdata = '0;
      case (sel_q)
         WB_SEL_ALU:  wdata = y_q;
         WB_SEL_MEM:  wdata = mem_rd;
         WB_SEL_PC:   wdata = pc_q;
         default:     wdata = '0;
      endcase
   end

   always_comb begin
      state_d   = state_q;
      pc_d      = pc_q;
      ir_d      = ir_q;
      y_d       = y_q;
      ld_d      = ld_q;
      st_d      = st_q;
      sel_d     = sel_q;
      to_cnt_d  = to_cnt_q;
      retire_d  = retire_q;
      err_to_d  = err_to_q;
      err_sel_d = err_sel_q;
      commit    = 1'b0;
      ready_c   = 1'b0;

      case (state_q)
         EMPTY: ready_c = 1'b1;
         ACTIVE: begin
            if (in_kill) begin
               state_d = (ld_q && !mem_rd_valid) ? LD_DRAIN : EMPTY;
            end else if (!ld_q || mem_rd_valid) begin
               commit  = 1'b1;
               state_d = EMPTY;
            end else begin
               state_d  = LD_WAIT;
               to_cnt_d = TO_W'(1);
            end
         end
         LD_WAIT: begin
            if (in_kill) begin
               state_d = mem_rd_valid ? EMPTY : LD_DRAIN;
            end else if (mem_rd_valid) begin
               commit  = 1'b1;
               state_d = EMPTY;
            end else if (LD_TIMEOUT != 0 && to_cnt_q == TO_LIMIT) begin
               // Abort: the load may still return, so the slot stays
               // closed until LD_DRAIN swallows that late data.
               err_to_d = 1'b1;
               state_d  = LD_DRAIN;
            end else if (LD_TIMEOUT != 0) begin
               to_cnt_d = to_cnt_q + TO_W'(1);
            end
         end
         LD_DRAIN: begin
            if (mem_rd_valid) state_d = EMPTY;
         end
         default: state_d = EMPTY;
      endcase

      if (commit) begin
         retire_d = retire_q + CNT_W'(1);
         ready_c  = 1'b1;
      end

      // Accept overrides the return to EMPTY, giving back-to-back issue.
      if (in_valid && ready_c && rst_n) begin
         state_d   = ACTIVE;
         pc_d      = in_pc;
         ir_d      = in_ir;
         y_d       = in_y;
         ld_d      = in_op_ld;
         st_d      = in_op_st;
         sel_d     = dec_sel;
         to_cnt_d  = '0;
         err_sel_d = err_sel_q | dec_err;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= EMPTY;
         pc_q      <= '0;
         ir_q      <= '0;
         y_q       <= '0;
         ld_q      <= 1'b0;
         st_q      <= 1'b0;
         sel_q     <= WB_SEL_ALU;
         to_cnt_q  <= '0;
         retire_q  <= '0;
         err_to_q  <= 1'b0;
         err_sel_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         pc_q      <= pc_d;
         ir_q      <= ir_d;
         y_q       <= y_d;
         ld_q      <= ld_d;
         st_q      <= st_d;
         sel_q     <= sel_d;
         to_cnt_q  <= to_cnt_d;
         retire_q  <= retire_d;
         err_to_q  <= err_to_d;
         err_sel_q <= err_sel_d;
      end
   end

   // Gated by rst_n so the stage reads as not-ready while held in reset.
   assign in_ready       = ready_c & rst_n;
   assign rf_we          = commit & writes;
   assign rf_w_addr      = rf_we ? rc : '0;
   assign rf_w_data      = rf_we ? wdata : '0;
   assign fwd_valid      = slot_busy & writes & !pending;
   assign fwd_pending    = pending;
   assign fwd_addr       = slot_busy ? rc : '0;
   assign fwd_data       = fwd_valid ? wdata : '0;
   assign ir_out         = ir_q;
   assign retire_count   = retire_q;
   assign err_ld_timeout = err_to_q;
   assign err_sel        = err_sel_q;
   assign dbg_state      = state_q;

endmodule
